mips_bus_lsu: RTL and testbench
===============================

# mips_bus_lsu

Parametrised Avalon-MM bus interface unit for the multicycle MIPS core. It arbitrates between an instruction-fetch port and a data port and performs byte, halfword and word accesses with byte-lane steering and sign/zero extension. It optionally converts between big-endian CPU values and the little-endian bus, and enforces a waitrequest timeout. It replaces the ad-hoc fetch/load/store bus driving inside the CPU top level.

## Interface
- SWAP_ENDIAN, 1: 1 = CPU values big-endian, bus little-endian (byte-swap words and halves); 0 = no swap.
- DATA_PRIORITY, 1: 1 = data port wins simultaneous requests; 0 = fetch port wins.
- TIMEOUT_CYCLES, 0: max consecutive waitrequest-high cycles per access; 0 disables timeout.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- if_req  in  1  fetch request, level, held until if_done.
- if_addr  in  32  fetch address, word-aligned.
- if_rdata  out  32  fetched word (swapped per SWAP_ENDIAN), valid while if_done.
- if_done  out  1  one-cycle fetch completion pulse.
- d_req  in  1  data request, level, held until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- d_signed  in  1  sign-extend loads (byte/half).
- d_addr  in  32  byte address.
- d_wdata  in  32  store value, right-justified.
- d_rdata  out  32  load result, valid while d_done.
- d_done  out  1  one-cycle data completion pulse.
- d_err  out  1  with d_done: misaligned/illegal or timeout.
- address  out  32  Avalon address, always word-aligned.
- read, write  out  1  Avalon strobes.
- waitrequest  in  1  Avalon stall.
- writedata  out  32  Avalon write data.
- byteenable  out  4  Avalon lane enables.
- readdata  in  32  Avalon read data.
- busy  out  1  state != IDLE.
- timeout_err  out  1  sticky timeout flag, cleared only by reset.

## Operation
- FSM: IDLE, ACCESS, DONE.
- IDLE: req sampled only here. Both req high -> grant per DATA_PRIORITY. Request fields captured into registers; all bus outputs are registered.
  - Data request misaligned (half with addr[0]=1, word with addr[1:0]!=0) or d_size=11 -> DONE with d_err=1, no bus cycle.
  - Otherwise -> ACCESS.
- ACCESS: read or write held high; address, writedata and byteenable held stable while waitrequest=1.
  - Transfer completes in the cycle where the strobe is high and waitrequest=0. readdata is sampled in that cycle. -> DONE, strobe drops.
- DONE: granted port's done pulses for one cycle with registered rdata; -> IDLE. The ungranted port's req stays pending and is served next.
- Lanes: o = addr[1:0]; address = {addr[31:2],2'b00}.
  - Byte: byteenable = 0001<<o; wdata[7:0] replicated on all 4 lanes.
  - Half: byteenable = 0011<<o. Half value h (SWAP_ENDIAN=1: {h[7:0],h[15:8]}) replicated on both halves.
  - Word: byteenable = 1111; writedata = SWAP_ENDIAN ? byteswap(wdata) : wdata.
  - Fetch: read, byteenable 1111.
- Loads: extract lane(s) at o. Half = SWAP_ENDIAN ? {lane o, lane o+1} : {lane o+1, lane o}. Word swapped per SWAP_ENDIAN. Byte/half sign-extended if d_signed, else zero-extended.
- Timeout (TIMEOUT_CYCLES=N>0): counter clears on entering ACCESS and increments each waitrequest-high cycle. Reaching N -> drop strobe, go to DONE, d_err=1 (for a fetch, if_done with if_rdata=0), set timeout_err.
- Stores: d_rdata = 0.

## Timing
- Reset (asynchronous, immediate): state IDLE; address, writedata, rdata = 0; read, write, byteenable, done, d_err, busy, timeout_err = 0. A reset mid-access drops strobes immediately and no done is issued.
- Minimum latency: req high in IDLE cycle 0 -> strobe cycle 1 -> done cycle 2 (waitrequest=0). Each waitrequest-high cycle adds one.
- Error path: req cycle 0 -> done+d_err cycle 1.
- Requester must update or drop req by the cycle after done (IDLE). Back-to-back accesses every 3 cycles.
- Simultaneous requests never both granted; loser waits exactly one full access.
- Timeout with N=4: strobe cycles 1..4 all stalled -> done+err cycle 5.

## Test plan
- SWAP_ENDIAN=1, fetch 0xBFC00000, readdata 0x44332211, waitrequest 0 -> read cycle 1, address 0xBFC00000, byteenable 1111; cycle 2 if_done, if_rdata 0x11223344.
- Signed byte load addr 0x1003, readdata 0x80223344 -> address 0x1000, byteenable 1000, d_rdata 0xFFFFFF80; unsigned -> 0x00000080.
- Half store 0x2002 data 0x0000ABCD, waitrequest high 3 cycles -> writedata 0xCDABCDAB, byteenable 1100, all stable 4 cycles, d_done 1 cycle after release.
- Word load 0x3001 -> no read/write ever asserted, d_done+d_err next cycle; d_size=11 same.
- Both req high, DATA_PRIORITY=1 -> data access first, fetch issued in the IDLE after d_done; DATA_PRIORITY=0 reversed.
- TIMEOUT_CYCLES=4, waitrequest stuck high -> strobe dropped after 4 cycles, d_err, timeout_err stays 1; reset mid-ACCESS -> read 0 immediately, no done.

Source files
------------

// File: rtl/mips_bus_lsu_if.sv
// CPU-side request ports and Avalon-MM master signals of mips_bus_lsu.
// The master modport is the bus unit's view; slave is the CPU/memory side.
interface mips_bus_lsu_if;
   // instruction fetch port
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_done;
   // data port
   logic        d_req;
   logic        d_we;
   logic [1:0]  d_size;
   logic        d_signed;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_done;
   logic        d_err;
   // Avalon-MM master
   logic [31:0] address;
   logic        read;
   logic        write;
   logic        waitrequest;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic [31:0] readdata;

   modport master (
      input  if_req, if_addr, d_req, d_we, d_size, d_signed, d_addr, d_wdata,
             waitrequest, readdata,
      output if_rdata, if_done, d_rdata, d_done, d_err,
             address, read, write, writedata, byteenable
   );

   modport slave (
      output if_req, if_addr, d_req, d_we, d_size, d_signed, d_addr, d_wdata,
             waitrequest, readdata,
      input  if_rdata, if_done, d_rdata, d_done, d_err,
             address, read, write, writedata, byteenable
   );
endinterface

// File: rtl/mips_bus_lsu.sv
// Avalon-MM bus unit for the multicycle MIPS core: arbitrates fetch and data
// requests, steers byte lanes, extends loads, optionally byte-swaps between a
// big-endian CPU and a little-endian bus, and bounds waitrequest stalls.
module mips_bus_lsu #(
   parameter bit          SWAP_ENDIAN    = 1'b1,
   parameter bit          DATA_PRIORITY  = 1'b1,
   parameter int unsigned TIMEOUT_CYCLES = 0
) (
   input  logic           clk,
   input  logic           reset,
   mips_bus_lsu_if.master bus,
   output logic           busy,
   output logic           timeout_err
);

   localparam int unsigned   CW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

   // Byte order of a halfword / word as it travels between CPU and bus.
   function automatic logic [15:0] half_order(input logic [15:0] h);
      return SWAP_ENDIAN ? {h[7:0], h[15:8]} : h;
   endfunction

   function automatic logic [31:0] word_order(input logic [31:0] w);
      return SWAP_ENDIAN ? {w[7:0], w[15:8], w[23:16], w[31:24]} : w;
   endfunction

   state_t        r_state, w_state;
   logic          r_is_data, w_is_data;
   logic          r_we, w_we;
   logic [1:0]    r_size, w_size;
   logic          r_signed, w_signed;
   logic [1:0]    r_off, w_off;
   logic [31:0]   r_address, w_address;
   logic [31:0]   r_writedata, w_writedata;
   logic [3:0]    r_byteenable, w_byteenable;
   logic          r_read, w_read;
   logic          r_write, w_write;
   logic [31:0]   r_rdata, w_rdata;
   logic          r_if_done, w_if_done;
   logic          r_d_done, w_d_done;
   logic          r_d_err, w_d_err;
   logic          r_timeout_err, w_timeout_err;
   logic [CW-1:0] r_cnt, w_cnt;

   logic          w_grant_data;
   logic [1:0]    w_d_off;
   logic          w_d_legal;
   logic [31:0]   w_st_data;
   logic [3:0]    w_st_be;
   logic [31:0]   w_lane_shift;
   logic [15:0]   w_half;
   logic [31:0]   w_load;

   assign w_grant_data = bus.d_req & (DATA_PRIORITY | ~bus.if_req);
   assign w_d_off      = bus.d_addr[1:0];
   assign w_lane_shift = bus.readdata >> {r_off, 3'b000};
   assign w_half       = half_order(w_lane_shift[15:0]);

   // Store lane steering, byte enables and alignment check for the data request
   always_comb begin
      // NOTE: every combinational output is given a value before the case so no path leaves it unassigned (no latches).
      w_st_data = word_order(bus.d_wdata);
      w_st_be   = 4'b1111;
      w_d_legal = 1'b1;
      case (bus.d_size)
         2'b00: begin
            w_st_data = {4{bus.d_wdata[7:0]}};
            w_st_be   = 4'b0001 << w_d_off;
         end
         2'b01: begin
            w_st_data = {2{half_order(bus.d_wdata[15:0])}};
            w_st_be   = 4'b0011 << w_d_off;
            w_d_legal = ~w_d_off[0];
         end
         2'b10:   w_d_legal = (w_d_off == 2'b00);
         default: w_d_legal = 1'b0;
      endcase
   end

   // Extract the addressed lane(s) of readdata and extend to a right-justified value
   always_comb begin
      w_load = word_order(bus.readdata);
      if (r_is_data) begin
         case (r_size)
            2'b00:   w_load = {{24{r_signed & w_lane_shift[7]}}, w_lane_shift[7:0]};
            2'b01:   w_load = {{16{r_signed & w_half[15]}}, w_half};
            default: w_load = word_order(bus.readdata);
         endcase
      end
   end

   // Next state and next register values of the access sequencer
   always_comb begin
      w_state       = r_state;
      w_is_data     = r_is_data;
      w_we          = r_we;
      w_size        = r_size;
      w_signed      = r_signed;
      w_off         = r_off;
      w_address     = r_address;
      w_writedata   = r_writedata;
      w_byteenable  = r_byteenable;
      w_read        = r_read;
      w_write       = r_write;
      w_rdata       = r_rdata;
      w_if_done     = 1'b0;
      w_d_done      = 1'b0;
      w_d_err       = 1'b0;
      w_timeout_err = r_timeout_err;
      w_cnt         = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_grant_data) begin
               w_is_data = 1'b1;
               w_we      = bus.d_we;
               w_size    = bus.d_size;
               w_signed  = bus.d_signed;
               w_off     = w_d_off;
               if (w_d_legal) begin
                  w_state      = S_ACCESS;
                  w_address    = {bus.d_addr[31:2], 2'b00};
                  w_writedata  = w_st_data;
                  w_byteenable = w_st_be;
                  w_read       = ~bus.d_we;
                  w_write      = bus.d_we;
                  w_cnt        = '0;
               end else begin
                  // Misaligned or illegal size: report immediately, bus untouched
                  w_state  = S_DONE;
                  w_d_done = 1'b1;
                  w_d_err  = 1'b1;
                  w_rdata  = '0;
               end
            end else if (bus.if_req) begin
               w_is_data    = 1'b0;
               w_off        = 2'b00;
               w_state      = S_ACCESS;
               w_address    = bus.if_addr & 32'hFFFF_FFFC;
               w_byteenable = 4'b1111;
               w_read       = 1'b1;
               w_write      = 1'b0;
               w_cnt        = '0;
            end
         end
         S_ACCESS: begin
            if (!bus.waitrequest) begin
               w_state   = S_DONE;
               w_read    = 1'b0;
               w_write   = 1'b0;
               w_rdata   = (r_is_data && r_we) ? '0 : w_load;
               w_if_done = ~r_is_data;
               w_d_done  = r_is_data;
            end else if (TIMEOUT_CYCLES != 0 && r_cnt == TO_LAST) begin
               // Stall budget exhausted: abandon the transfer and flag it
               w_state       = S_DONE;
               w_read        = 1'b0;
               w_write       = 1'b0;
               w_rdata       = '0;
               w_if_done     = ~r_is_data;
               w_d_done      = r_is_data;
               w_d_err       = r_is_data;
               w_timeout_err = 1'b1;
            end else begin
               w_cnt = r_cnt + 1'b1;
            end
         end
         S_DONE:  w_state = S_IDLE;
         default: w_state = S_IDLE;
      endcase
   end

   // State and registered bus/port outputs; reset drops strobes at once
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_is_data     <= 1'b0;
         r_we          <= 1'b0;
         r_size        <= 2'b00;
         r_signed      <= 1'b0;
         r_off         <= 2'b00;
         r_address     <= '0;
         r_writedata   <= '0;
         r_byteenable  <= '0;
         r_read        <= 1'b0;
         r_write       <= 1'b0;
         r_rdata       <= '0;
         r_if_done     <= 1'b0;
         r_d_done      <= 1'b0;
         r_d_err       <= 1'b0;
         r_timeout_err <= 1'b0;
         r_cnt         <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
         r_state       <= w_state;
         r_is_data     <= w_is_data;
         r_we          <= w_we;
         r_size        <= w_size;
         r_signed      <= w_signed;
         r_off         <= w_off;
         r_address     <= w_address;
         r_writedata   <= w_writedata;
         r_byteenable  <= w_byteenable;
         r_read        <= w_read;
         r_write       <= w_write;
         r_rdata       <= w_rdata;
         r_if_done     <= w_if_done;
         r_d_done      <= w_d_done;
         r_d_err       <= w_d_err;
         r_timeout_err <= w_timeout_err;
         r_cnt         <= w_cnt;
      end
   end

   assign bus.address    = r_address;
   assign bus.read       = r_read;
   assign bus.write      = r_write;
   assign bus.writedata  = r_writedata;
   assign bus.byteenable = r_byteenable;
   assign bus.if_rdata   = r_rdata;
   assign bus.if_done    = r_if_done;
   assign bus.d_rdata    = r_rdata;
   assign bus.d_done     = r_d_done;
   assign bus.d_err      = r_d_err;
   assign busy           = (r_state != S_IDLE);
   assign timeout_err    = r_timeout_err;

endmodule

// File: tb/tb_mips_bus_lsu.sv
// Bench for mips_bus_lsu: two instances (swap/data-priority/timeout=4 and
// no-swap/fetch-priority/no-timeout) against a byte-addressed memory model.
module tb_mips_bus_lsu;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  if_req = '0, d_req = '0;   // bit 1 -> u_dut1, bit 0 -> u_dut0
   logic        d_we = 1'b0, d_signed = 1'b0, waitrequest = 1'b0;
   logic [1:0]  d_size = '0;
   logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, readdata = '0;
   logic        busy0, busy1, terr0, terr1;
   int          n_tests = 0, n_fail = 0;

   always #5 clk = ~clk;

   mips_bus_lsu_if b0 ();
   mips_bus_lsu_if b1 ();

   assign b0.if_req = if_req[0];  assign b1.if_req = if_req[1];
   assign b0.d_req  = d_req[0];   assign b1.d_req  = d_req[1];
   assign b0.if_addr = if_addr;   assign b1.if_addr = if_addr;
   assign b0.d_we = d_we;         assign b1.d_we = d_we;
   assign b0.d_size = d_size;     assign b1.d_size = d_size;
   assign b0.d_signed = d_signed; assign b1.d_signed = d_signed;
   assign b0.d_addr = d_addr;     assign b1.d_addr = d_addr;
   assign b0.d_wdata = d_wdata;   assign b1.d_wdata = d_wdata;
   assign b0.waitrequest = waitrequest; assign b1.waitrequest = waitrequest;
   assign b0.readdata = readdata; assign b1.readdata = readdata;

   mips_bus_lsu #(.SWAP_ENDIAN(1'b0), .DATA_PRIORITY(1'b0), .TIMEOUT_CYCLES(0)) u_dut0 (
      .clk(clk), .reset(reset), .bus(b0.master), .busy(busy0), .timeout_err(terr0));
   mips_bus_lsu #(.SWAP_ENDIAN(1'b1), .DATA_PRIORITY(1'b1), .TIMEOUT_CYCLES(4)) u_dut1 (
      .clk(clk), .reset(reset), .bus(b1.master), .busy(busy1), .timeout_err(terr1));

   typedef struct packed {
      logic [31:0] address;
      logic [31:0] writedata;
      logic [3:0]  be;
      logic        read;
      logic        write;
      logic [31:0] if_rdata;
      logic        if_done;
      logic [31:0] d_rdata;
      logic        d_done;
      logic        d_err;
      logic        busy;
      logic        terr;
   } obs_t;

   obs_t obs [2];
   assign obs[0] = '{b0.address, b0.writedata, b0.byteenable, b0.read, b0.write,
                     b0.if_rdata, b0.if_done, b0.d_rdata, b0.d_done, b0.d_err, busy0, terr0};
   assign obs[1] = '{b1.address, b1.writedata, b1.byteenable, b1.read, b1.write,
                     b1.if_rdata, b1.if_done, b1.d_rdata, b1.d_done, b1.d_err, busy1, terr1};

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // ---------------- reference model (memory-order view of the access) ----------------
   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction

   function automatic bit m_legal(input logic [1:0] sz, input logic [31:0] a);
      if (sz == 2'b11) return 1'b0;
      return (int'(a[1:0]) % nbytes(sz)) == 0;
   endfunction

   function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
      logic [3:0] be = '0;
      for (int i = 0; i < nbytes(sz); i++) be[(int'(a[1:0]) + i) % 4] = 1'b1;
      return be;
   endfunction

   // Value bytes placed at their byte addresses; the pattern repeats across the word.
   function automatic logic [31:0] m_wdata(input bit swap, input logic [1:0] sz,
                                           input logic [31:0] a, input logic [31:0] wd);
      logic [7:0] lane [4];
      logic [7:0] b;
      int n = nbytes(sz);
      int o = int'(a[1:0]);
      for (int i = 0; i < 4; i++) lane[i] = 8'h00;
      for (int i = 0; i < n; i++) begin
         b = swap ? 8'(wd >> (8 * (n - 1 - i))) : 8'(wd >> (8 * i));
         for (int r = 0; r < 4; r += n) lane[(o + i + r) % 4] = b;
      end
      return {lane[3], lane[2], lane[1], lane[0]};
   endfunction

   // Bytes read from addresses a..a+n-1, assembled big- or little-endian, then extended.
   function automatic logic [31:0] m_load(input bit swap, input logic [1:0] sz, input bit sg,
                                          input logic [31:0] a, input logic [31:0] rd);
      int n = nbytes(sz);
      int o = int'(a[1:0]);
      logic [31:0] v = '0;
      logic [7:0]  b;
      for (int i = 0; i < n; i++) begin
         b = 8'(rd >> (8 * ((o + i) % 4)));
         if (swap) v = (v << 8) | 32'(b);
         else      v = v | (32'(b) << (8 * i));
      end
      if (sg && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
      return v;
   endfunction

   // ---------------- stimulus ----------------
   // One access on both instances in lockstep, waitrequest high for 'waits' strobe cycles.
   task automatic run_access(input string name, input bit is_data, input logic we,
                             input logic [1:0] sz, input bit sg, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] rd, input int waits);
      bit legal = !is_data || m_legal(sz, a);
      logic [1:0] esz = is_data ? sz : 2'b10;
      @(posedge clk); #1;
      readdata = rd; waitrequest = 1'b0;
      d_we = we; d_size = sz; d_signed = sg; d_addr = a; d_wdata = wd; if_addr = a;
      if (is_data) d_req = 2'b11; else if_req = 2'b11;
      if (legal) begin
         for (int k = 0; k <= waits; k++) begin
            @(posedge clk); #1;
            waitrequest = (k < waits);
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
               check($sformatf("%s d%0d c%0d read", name, d, k), obs[d].read, is_data ? !we : 1'b1);
               check($sformatf("%s d%0d c%0d write", name, d, k), obs[d].write, is_data ? we : 1'b0);
               check($sformatf("%s d%0d c%0d addr", name, d, k), obs[d].address, a & 32'hFFFF_FFFC);
               check($sformatf("%s d%0d c%0d be", name, d, k), obs[d].be, m_be(esz, a));
               if (is_data && we)
                  check($sformatf("%s d%0d c%0d wdata", name, d, k), obs[d].writedata,
                        m_wdata(d == 1, sz, a, wd));
               check($sformatf("%s d%0d c%0d done", name, d, k), obs[d].if_done | obs[d].d_done, 1'b0);
               check($sformatf("%s d%0d c%0d busy", name, d, k), obs[d].busy, 1'b1);
            end
         end
      end
      @(posedge clk); #1;
      if_req = '0; d_req = '0; waitrequest = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("%s d%0d strobes", name, d), {obs[d].read, obs[d].write}, 2'b00);
         check($sformatf("%s d%0d if_done", name, d), obs[d].if_done, !is_data);
         check($sformatf("%s d%0d d_done", name, d), obs[d].d_done, is_data);
         check($sformatf("%s d%0d d_err", name, d), obs[d].d_err, !legal);
         if (!is_data)
            check($sformatf("%s d%0d if_rdata", name, d), obs[d].if_rdata, m_load(d == 1, 2'b10, 1'b0, a, rd));
         else if (legal)
            check($sformatf("%s d%0d d_rdata", name, d), obs[d].d_rdata,
                  we ? 32'h0 : m_load(d == 1, sz, sg, a, rd));
      end
      @(posedge clk); #1;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("%s d%0d pulse end", name, d), obs[d].if_done | obs[d].d_done, 1'b0);
         check($sformatf("%s d%0d idle", name, d), obs[d].busy, 1'b0);
      end
   endtask

   task automatic priority_test();
      logic [31:0] da = 32'h0000_0040;
      logic [31:0] fa = 32'h0000_0080;
      logic [31:0] rd = 32'hA1B2_C3D4;
      @(posedge clk); #1;
      if_addr = fa; d_addr = da; d_we = 1'b0; d_size = 2'b10; d_signed = 1'b0;
      readdata = rd; waitrequest = 1'b0; if_req = 2'b11; d_req = 2'b11;
      @(posedge clk); #1; @(negedge clk);
      check("prio1 addr d1", obs[1].address, da);
      check("prio1 addr d0", obs[0].address, fa);
      check("prio1 read", {obs[1].read, obs[0].read}, 2'b11);
      @(posedge clk); #1;
      d_req[1] = 1'b0; if_req[0] = 1'b0;
      @(negedge clk);
      check("prio1 done d1", {obs[1].d_done, obs[1].if_done}, 2'b10);
      check("prio1 done d0", {obs[0].d_done, obs[0].if_done}, 2'b01);
      check("prio1 d_rdata d1", obs[1].d_rdata, m_load(1'b1, 2'b10, 1'b0, da, rd));
      check("prio1 if_rdata d0", obs[0].if_rdata, m_load(1'b0, 2'b10, 1'b0, fa, rd));
      @(posedge clk); #1; @(negedge clk);
      check("prio idle gap", {obs[1].busy, obs[0].busy, obs[1].read, obs[0].read}, 4'b0000);
      @(posedge clk); #1; @(negedge clk);
      check("prio2 addr d1", obs[1].address, fa);
      check("prio2 addr d0", obs[0].address, da);
      check("prio2 read", {obs[1].read, obs[0].read}, 2'b11);
      @(posedge clk); #1;
      if_req = '0; d_req = '0;
      @(negedge clk);
      check("prio2 done d1", {obs[1].d_done, obs[1].if_done}, 2'b01);
      check("prio2 done d0", {obs[0].d_done, obs[0].if_done}, 2'b10);
      @(posedge clk); #1; @(negedge clk);
      check("prio end", {obs[1].d_done, obs[1].if_done, obs[0].d_done, obs[0].if_done}, 4'b0000);
   endtask

   // Stalled access on u_dut1 only (u_dut0 has no timeout and stays stuck until reset).
   task automatic timeout_test(input string name, input bit is_data);
      @(posedge clk); #1;
      readdata = 32'hDEAD_BEEF; waitrequest = 1'b1;
      d_we = 1'b0; d_size = 2'b10; d_signed = 1'b0; d_addr = 32'h500; if_addr = 32'h600;
      if (is_data) d_req = 2'b11; else if_req = 2'b11;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1; @(negedge clk);
         check($sformatf("%s c%0d read", name, k), obs[1].read, 1'b1);
         check($sformatf("%s c%0d done", name, k), obs[1].d_done | obs[1].if_done, 1'b0);
      end
      @(posedge clk); #1;
      d_req = '0; if_req = '0;
      @(negedge clk);
      check($sformatf("%s read drop", name), obs[1].read, 1'b0);
      check($sformatf("%s d_done", name), obs[1].d_done, is_data);
      check($sformatf("%s if_done", name), obs[1].if_done, !is_data);
      check($sformatf("%s d_err", name), obs[1].d_err, is_data);
      check($sformatf("%s rdata", name), is_data ? obs[1].d_rdata : obs[1].if_rdata, 32'h0);
      check($sformatf("%s terr", name), obs[1].terr, 1'b1);
      @(posedge clk); #1; @(negedge clk);
      check($sformatf("%s terr sticky", name), obs[1].terr, 1'b1);
      check($sformatf("%s pulse end", name), obs[1].d_done | obs[1].if_done, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] a, wd, rd;
      logic [1:0]  sz;
      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("rst d%0d addr", d), obs[d].address, 32'h0);
         check($sformatf("rst d%0d wdata", d), obs[d].writedata, 32'h0);
         check($sformatf("rst d%0d rdata", d), obs[d].d_rdata, 32'h0);
         check($sformatf("rst d%0d flags", d),
               {obs[d].read, obs[d].write, obs[d].be, obs[d].if_done, obs[d].d_done,
                obs[d].d_err, obs[d].busy, obs[d].terr}, 12'h000);
      end
      reset = 1'b0;

      // directed cases
      run_access("fetch boot", 1'b0, 1'b0, 2'b10, 1'b0, 32'hBFC0_0000, 32'h0, 32'h4433_2211, 0);
      run_access("lb signed", 1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0, 32'h8022_3344, 0);
      run_access("lbu", 1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 32'h8022_3344, 0);
      run_access("sh stall", 1'b1, 1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 3);
      run_access("lw misalign", 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0, 32'h1234_5678, 0);
      run_access("size 11", 1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_3000, 32'h0, 32'h1234_5678, 0);
      run_access("sh odd", 1'b1, 1'b1, 2'b01, 1'b0, 32'h0000_3003, 32'h1111_2222, 32'h0, 0);
      run_access("lh signed", 1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_4002, 32'h0, 32'h9A78_5634, 1);
      run_access("sw", 1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_4004, 32'h0102_0304, 32'h0, 2);
      priority_test();

      // randomized accesses (stall count kept below the timeout)
      for (int it = 0; it < 48; it++) begin
         a  = $urandom;
         wd = $urandom;
         rd = $urandom;
         sz = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0)
            run_access($sformatf("rnd%0d fetch", it), 1'b0, 1'b0, 2'b10, 1'b0, a & 32'hFFFF_FFFC,
                       32'h0, rd, $urandom_range(0, 3));
         else
            run_access($sformatf("rnd%0d data", it), 1'b1, 1'($urandom_range(0, 1)), sz,
                       1'($urandom_range(0, 1)), a, wd, rd, $urandom_range(0, 3));
      end

      // timeout on u_dut1
      timeout_test("timeout data", 1'b1);
      timeout_test("timeout fetch", 1'b0);

      // reset in the middle of a stalled fetch
      @(posedge clk); #1;
      waitrequest = 1'b1; if_addr = 32'h700; if_req = 2'b11;
      repeat (2) begin
         @(posedge clk); #1; @(negedge clk);
         check("pre-reset read", obs[1].read, 1'b1);
      end
      #2;
      reset = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("mid-rst d%0d read", d), obs[d].read, 1'b0);
         check($sformatf("mid-rst d%0d busy", d), obs[d].busy, 1'b0);
         check($sformatf("mid-rst d%0d terr", d), obs[d].terr, 1'b0);
         check($sformatf("mid-rst d%0d addr", d), obs[d].address, 32'h0);
      end
      if_req = '0; waitrequest = 1'b0;
      @(posedge clk); @(negedge clk);
      reset = 1'b0;
      repeat (3) begin
         @(posedge clk); #1; @(negedge clk);
         for (int d = 0; d < 2; d++)
            check($sformatf("post-rst d%0d no done", d),
                  {obs[d].if_done, obs[d].d_done, obs[d].read}, 3'b000);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
